// File: rtl/egress_pkg.sv
// Shared egress-queue definitions: default geometry, statistics width and the
// statistics bundle consumed by higher-level port logic.
package egress_pkg;

  localparam int EGRESS_DEFAULT_WIDTH = 128;
  localparam int EGRESS_DEFAULT_DEPTH = 8;
  localparam int EGRESS_STAT_W        = 32;

  typedef struct packed {
    logic [EGRESS_STAT_W-1:0] tx_words;
    logic [EGRESS_STAT_W-1:0] stall_cycles;
  } egress_stats_t;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [EGRESS_STAT_W-1:0] sat_inc(input logic [EGRESS_STAT_W-1:0] v);
    return (v == '1) ? v : v + EGRESS_STAT_W'(1);
  endfunction

endpackage

// File: rtl/egress_fifo_mem.sv
// Storage array for the egress FIFO: one synchronous write port and one
// asynchronous read port, no reset.
module egress_fifo_mem #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/egress_fifo.sv
// First-word-fall-through egress FIFO with occupancy, almost-full and flush.
// Optional statistics counters are built when EGRESS_FIFO_STATS_EN is defined.
module egress_fifo
  import egress_pkg::*;
#(
  parameter int WIDTH        = EGRESS_DEFAULT_WIDTH,
  parameter int DEPTH        = EGRESS_DEFAULT_DEPTH,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
`ifdef EGRESS_FIFO_STATS_EN
  ,
  output logic [EGRESS_STAT_W-1:0]   tx_words,
  output logic [EGRESS_STAT_W-1:0]   stall_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshake: a word moves on a side only in a cycle where valid && ready at
  // the rising edge. Both ready/valid outputs come from count alone, so
  // in_ready ignores out_ready and a full FIFO never accepts, even on a pop.
  assign in_ready    = (count != CW'(DEPTH));
  assign out_valid   = (count != '0);
  assign almost_full = (count >= CW'(AFULL_THRESH));
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;

  egress_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush && reset_n),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

  // Flush outranks both handshakes; the word offered in a flush cycle is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

`ifdef EGRESS_FIFO_STATS_EN
  // Counters survive flush; a flush cycle performs no pop, so tx_words holds.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_words     <= '0;
      stall_cycles <= '0;
    end else begin
      if (pop && !flush)          tx_words     <= sat_inc(tx_words);
      if (out_valid && !out_ready) stall_cycles <= sat_inc(stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_egress_fifo.sv
// Bench for egress_fifo: directed steps from the test plan followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_egress_fifo;

  localparam int WIDTH = 128;
  localparam int DEPTH = 8;
  localparam int AFULL = DEPTH - 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             almost_full;
`ifdef EGRESS_FIFO_STATS_EN
  logic [31:0]      tx_words;
  logic [31:0]      stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [31:0]      m_tx    = '0;
  logic [31:0]      m_stall = '0;

  always #5 clk = ~clk;

  egress_fifo #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .count        (count),
    .almost_full  (almost_full)
`ifdef EGRESS_FIFO_STATS_EN
    ,
    .tx_words     (tx_words),
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour for one rising edge, from the inputs held across it.
  task automatic model_edge();
    int  sz;
    bit  do_pop;
    bit  do_push;
    sz = exp_q.size();
    if (!reset_n) begin
      exp_q.delete();
      m_tx    = '0;
      m_stall = '0;
    end else begin
      if (sz > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (flush) begin
        exp_q.delete();
      end else begin
        do_pop  = (sz > 0) && out_ready;
        do_push = in_valid && (sz < DEPTH);
        if (do_pop) begin
          void'(exp_q.pop_front());
          if (m_tx != 32'hFFFF_FFFF) m_tx++;
        end
        if (do_push) exp_q.push_back(in_data);
      end
    end
  endtask

  task automatic check_all();
    int sz;
    sz = exp_q.size();
    chk("count",       WIDTH'(count),       WIDTH'(sz));
    chk("out_valid",   WIDTH'(out_valid),   WIDTH'(sz > 0));
    chk("in_ready",    WIDTH'(in_ready),    WIDTH'(sz < DEPTH));
    chk("almost_full", WIDTH'(almost_full), WIDTH'(sz >= AFULL));
    if (sz > 0) chk("out_data", out_data, exp_q[0]);
`ifdef EGRESS_FIFO_STATS_EN
    chk("tx_words",     WIDTH'(tx_words),     WIDTH'(m_tx));
    chk("stall_cycles", WIDTH'(stall_cycles), WIDTH'(m_stall));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    cycle();
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [WIDTH-1:0] w;
    logic [31:0]      s0;
    logic [31:0]      t0;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset, then idle
    cycle();
    cycle();
    chk("reset_count",    WIDTH'(count),    '0);
    chk("reset_in_ready", WIDTH'(in_ready), WIDTH'(1));
    reset_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Fill with 1..8, offer a 9th that must not be taken
    for (int i = 1; i <= DEPTH; i++) drive(1'b1, WIDTH'(i), 1'b0, 1'b0);
    chk("full_in_ready", WIDTH'(in_ready), '0);
    drive(1'b1, WIDTH'(9), 1'b0, 1'b0);
    chk("ninth_rejected", WIDTH'(count), WIDTH'(DEPTH));

    // Drain in order
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_order", out_data, WIDTH'(i));
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    chk("drained_out_valid", WIDTH'(out_valid), '0);

    // Simultaneous push/pop at count 3, long enough to wrap the pointers
    for (int i = 0; i < 3; i++) drive(1'b1, rand_word(), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, rand_word(), 1'b1, 1'b0);
    chk("steady_count3", WIDTH'(count), WIDTH'(3));

    // Full with concurrent push and pop: only the pop happens
    for (int i = 0; i < DEPTH - 3; i++) drive(1'b1, rand_word(), 1'b0, 1'b0);
    w = rand_word();
    drive(1'b1, w, 1'b1, 1'b0);
    chk("full_pop_only", WIDTH'(count), WIDTH'(DEPTH - 1));
    drive(1'b1, w, 1'b0, 1'b0);
    chk("reoffer_taken", WIDTH'(count), WIDTH'(DEPTH));
    chk("reoffer_tail", exp_q[DEPTH-1], w);

    // Flush at count 5 with a word on offer
    for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, rand_word(), 1'b0, 1'b0);
    drive(1'b1, rand_word(), 1'b0, 1'b1);
    chk("flush_count",     WIDTH'(count),     '0);
    chk("flush_out_valid", WIDTH'(out_valid), '0);
    w = rand_word();
    drive(1'b1, w, 1'b0, 1'b0);
    chk("post_flush_data", out_data, w);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Stall and delivery counters
    for (int i = 0; i < 4; i++) drive(1'b1, rand_word(), 1'b0, 1'b0);
    s0 = m_stall;
    for (int i = 0; i < 10; i++) drive(1'b0, '0, 1'b0, 1'b0);
    t0 = m_tx;
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
`ifdef EGRESS_FIFO_STATS_EN
    chk("stall_10", WIDTH'(stall_cycles), WIDTH'(s0 + 32'd10));
    chk("tx_4",     WIDTH'(tx_words),     WIDTH'(t0 + 32'd4));
`else
    chk("stats_off_empty", WIDTH'(count), WIDTH'(s0 - s0 + t0 - t0));
`endif

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      drive(1'($urandom_range(0, 3) != 0), rand_word(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/egress_fifo.md
# egress_fifo

Parametrised egress queue for the switch datapath, replacing the single-register egress stage with a DEPTH-entry first-word-fall-through FIFO that has valid/ready handshakes on both sides. It sits between the switch fabric output and the port transmitter, and absorbs transmitter back-pressure without dropping words. It also provides occupancy, almost-full and flush control, plus optional statistics counters.

## Interface
- WIDTH, 128, data word width in bits (≥1)
- DEPTH, 8, number of entries (power of two, ≥2)
- AFULL_THRESH, DEPTH-2, occupancy at or above which almost_full asserts (1..DEPTH)
- clk  input  1  single clock; all logic on its rising edge
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk
- flush  input  1  discard all stored entries
- in_valid  input  1  producer has a word
- in_data  input  WIDTH  producer word
- in_ready  output  1  FIFO can accept a word
- out_valid  output  1  head word available
- out_data  output  WIDTH  head word
- out_ready  input  1  consumer takes head word
- count  output  $clog2(DEPTH+1)  current occupancy
- almost_full  output  1  count ≥ AFULL_THRESH
- tx_words  output  32  words delivered (EGRESS_FIFO_STATS_EN only)
- stall_cycles  output  32  cycles with out_valid && !out_ready (EGRESS_FIFO_STATS_EN only)

## Operation
- Push occurs when in_valid && in_ready. The word is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop occurs when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- in_ready = (count != DEPTH). It does not depend on out_ready, so a push is never accepted while full, even with a simultaneous pop.
- out_valid = (count != 0). out_data = mem[rd_ptr]. out_data is don't-care while out_valid=0.
- Count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop (legal whenever 0 < count < DEPTH)
- Pointers wrap from DEPTH-1 to 0. count never exceeds DEPTH and never goes below 0.
- Flush has priority over push and pop in the same cycle. Pointers and count clear to 0, and the word offered that cycle is not stored.
- Memory contents are not reset. Only pointers, count and counters are reset.
- Producers must hold in_valid/in_data until accepted. The FIFO does not check this.

## Timing
- Reset (reset_n=0 at a rising edge): rd_ptr=wr_ptr=0, count=0, out_valid=0, in_ready=1, almost_full=0, tx_words=0, stall_cycles=0.
- Write-to-read latency is 1 cycle. A word pushed at edge N appears on out_data with out_valid=1 after edge N; there is no same-cycle bypass.
- in_ready, out_valid, count and almost_full are all derived from registered state, with no combinational path from the in_* or out_ready inputs.
- Reset asserted mid-transfer empties the FIFO at that edge, and any word offered that cycle is lost.
- Flush takes effect at the edge where it is sampled. out_valid=0 from the next cycle.

## Configuration
- EGRESS_FIFO_STATS_EN defined:
  - tx_words increments on each pop.
  - stall_cycles increments each cycle with out_valid && !out_ready.
  - Both are 32-bit, saturate at 0xFFFFFFFF, clear on reset only (not on flush), and are registered.
- EGRESS_FIFO_STATS_EN undefined: both ports and their counters are absent. All other behaviour is identical.

## Structure
- Package egress_pkg holds:
  - EGRESS_DEFAULT_WIDTH=128
  - EGRESS_DEFAULT_DEPTH=8
  - EGRESS_STAT_W=32
  - a stats struct type {tx_words, stall_cycles} used by higher-level port logic
- Sub-module egress_fifo_mem holds the storage: a DEPTH×WIDTH register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr → rdata). It has no reset.
- Pointer, count, flag and stats logic lives in egress_fifo.

## Test plan
- Reset then idle:
  - reset_n=0 for 2 cycles → count=0, out_valid=0, in_ready=1, almost_full=0.
  - Stats enabled: counters read 0.
- Fill and drain (DEPTH=8, out_ready=0):
  - Push 0x1..0x8 → in_ready=0 after the 8th push; almost_full=1 from count=6.
  - A 9th offer is not accepted.
  - Set out_ready=1 → 0x1..0x8 emerge in order, one per cycle, then out_valid=0.
- Simultaneous push/pop at count=3 → count stays 3 and order is preserved. Repeat 20 cycles to exercise pointer wrap.
- Full with pop and push in the same cycle → only the pop happens, count 8→7, and the offered word is presented again and accepted next cycle.
- Flush with count=5 and in_valid=1 → count=0 and out_valid=0 next cycle. The flush-cycle word is absent, and the next push appears 1 cycle later.
- Stats (macro on):
  - Hold out_ready=0 for 10 cycles with count=4 → stall_cycles=10.
  - Drain → tx_words=4.
  - Flush leaves both counters unchanged.
